// File: rtl/mem_port_arbiter.sv
// Arbitrates one backing-memory port between instruction fetch (I) and data (D) requesters.
// D has fixed priority, bounded by a streak limit so a waiting fetch always makes progress.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int STREAK_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        o_dbg_state,
    output logic [STREAK_W-1:0] o_dbg_streak
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [STREAK_W-1:0] LP_MAX_STREAK = STREAK_W'(MAX_D_STREAK);

    state_t              r_state;
    logic                r_owner_d;
    logic [STREAK_W-1:0] r_streak;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_i_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_grant_d;
    logic w_grant_i;

    // Handshake: requester holds req with its fields stable until the one-cycle ack;
    // memory side holds mem_req with stable fields until mem_ready is seen in BUSY.
    assign w_grant_d = d_req && !(i_req && (r_streak == LP_MAX_STREAK));
    assign w_grant_i = !w_grant_d && i_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner_d   <= 1'b0;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d   <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        // Streak only grows while a fetch is actually being held off.
                        r_streak    <= i_req ? (r_streak + STREAK_W'(1)) : '0;
                        r_state     <= ST_BUSY;
                    end else if (w_grant_i) begin
                        r_owner_d   <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_streak    <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (!r_mem_we) begin
                            if (r_owner_d) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        r_i_ack <= !r_owner_d;
                        r_d_ack <= r_owner_d;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack        = r_i_ack;
    assign d_ack        = r_d_ack;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = (r_state != ST_IDLE);
    assign o_dbg_state  = r_state;
    assign o_dbg_streak = r_streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// a variable-latency memory responder, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MAX_D_STREAK = 4;
  localparam int STREAK_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic d_req = 1'b0;
  logic d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic busy;
  logic [1:0] o_dbg_state;
  logic [STREAK_W-1:0] o_dbg_streak;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D_STREAK), .STREAK_W(STREAK_W)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy),
    .o_dbg_state(o_dbg_state), .o_dbg_streak(o_dbg_streak)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- memory responder ----------------
  int ready_delay = 0;
  logic [DATA_W-1:0] rd_value = '0;
  int wait_cnt = 0;

  always @(negedge clk) begin
    if (mem_req && !mem_ready) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt > ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd_value;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // One transaction record; its life is grant -> memory wait -> ack cycle.
  logic m_in_mem = 0, m_ack_i = 0, m_ack_d = 0, m_is_d = 0;
  logic m_mem_req = 0, m_mem_we = 0;
  logic [ADDR_W-1:0] m_mem_addr = '0;
  logic [DATA_W-1:0] m_mem_wdata = '0, m_i_rdata = '0, m_d_rdata = '0;
  int m_streak = 0;
  logic [0:0] exp_q[$];
  logic [0:0] grant_hist[$];

  always @(posedge clk) begin
    if (reset) begin
      m_in_mem = 0; m_ack_i = 0; m_ack_d = 0; m_is_d = 0;
      m_mem_req = 0; m_mem_we = 0; m_mem_addr = '0; m_mem_wdata = '0;
      m_i_rdata = '0; m_d_rdata = '0; m_streak = 0;
      exp_q.delete();
    end else if (m_ack_i || m_ack_d) begin
      m_ack_i = 0;
      m_ack_d = 0;
    end else if (m_in_mem) begin
      if (mem_ready) begin
        if (!m_mem_we) begin
          if (m_is_d) m_d_rdata = mem_rdata;
          else m_i_rdata = mem_rdata;
        end
        m_in_mem = 0; m_mem_req = 0; m_mem_we = 0;
        m_ack_i = !m_is_d;
        m_ack_d = m_is_d;
      end
    end else if (d_req && !(i_req && m_streak == MAX_D_STREAK)) begin
      m_is_d = 1; m_mem_we = d_we; m_mem_addr = d_addr; m_mem_wdata = d_wdata;
      m_streak = i_req ? m_streak + 1 : 0;
      m_in_mem = 1; m_mem_req = 1;
      exp_q.push_back(1'b1);
      grant_hist.push_back(1'b1);
    end else if (i_req) begin
      m_is_d = 0; m_mem_we = 0; m_mem_addr = i_addr;
      m_streak = 0;
      m_in_mem = 1; m_mem_req = 1;
      exp_q.push_back(1'b0);
      grant_hist.push_back(1'b0);
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_iack = 0, n_dack = 0, mreq_cycles = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("i_ack", 32'(i_ack), 32'(m_ack_i));
      chk("d_ack", 32'(d_ack), 32'(m_ack_d));
      chk("i_rdata", 32'(i_rdata), 32'(m_i_rdata));
      chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
      chk("mem_req", 32'(mem_req), 32'(m_mem_req));
      chk("mem_we", 32'(mem_we), 32'(m_mem_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_mem_wdata));
      chk("busy", 32'(busy), 32'(m_in_mem || m_ack_i || m_ack_d));
      chk("dbg_idle", 32'(o_dbg_state == 2'd0), 32'(!(m_in_mem || m_ack_i || m_ack_d)));
      chk("dbg_streak", 32'(o_dbg_streak), 32'(m_streak));
      chk("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) fail_now("ack_without_grant");
        else chk("ack_owner", 32'(d_ack), 32'(exp_q.pop_front()));
      end
      if (i_ack) n_iack++;
      if (d_ack) n_dack++;
      if (mem_req) mreq_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  logic [ADDR_W-1:0] cap_i_addr, cap_d_addr;
  logic cap_i_we, cap_d_we, cap_i_valid, cap_d_valid;
  logic [DATA_W-1:0] cap_d_wdata, cap_i_rdata, cap_d_rdata;
  logic [STREAK_W-1:0] cap_i_streak;

  task automatic do_i(input logic [ADDR_W-1:0] a, output bit ok);
    i_req = 1'b1; i_addr = a; ok = 0; cap_i_valid = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (mem_req && !cap_i_valid) begin
        cap_i_addr = mem_addr; cap_i_we = mem_we; cap_i_valid = 1;
      end
      if (i_ack) begin
        ok = 1; cap_i_rdata = i_rdata; cap_i_streak = o_dbg_streak;
      end
    end
    i_req = 1'b0;
    if (!ok) fail_now("i_ack_timeout");
  endtask

  task automatic do_d(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                      input bit keep, output bit ok);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; ok = 0; cap_d_valid = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (mem_req && !cap_d_valid) begin
        cap_d_addr = mem_addr; cap_d_we = mem_we; cap_d_wdata = mem_wdata; cap_d_valid = 1;
      end
      if (d_ack) begin
        ok = 1; cap_d_rdata = d_rdata;
      end
    end
    if (!keep) d_req = 1'b0;
    if (!ok) fail_now("d_ack_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  int pat[7] = '{1, 1, 1, 1, 0, 1, 1};
  int base_i, base_d;

  initial begin
    bit ok, ok2;
    @(posedge clk);
    started = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_i_rdata", 32'(i_rdata), 32'd0);
    chk("rst_streak", 32'(o_dbg_streak), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single fetch
    ready_delay = 0; rd_value = 16'hBEEF; base_d = n_dack;
    do_i(16'h0010, ok);
    chk("t1_mem_addr", 32'(cap_i_addr), 32'h0010);
    chk("t1_mem_we", 32'(cap_i_we), 32'd0);
    chk("t1_i_rdata", 32'(cap_i_rdata), 32'hBEEF);
    chk("t1_no_d_ack", 32'(n_dack - base_d), 32'd0);
    @(negedge clk);

    // 2: data write
    do_d(1'b1, 16'h0200, 16'h1234, 0, ok);
    chk("t2_mem_we", 32'(cap_d_we), 32'd1);
    chk("t2_mem_wdata", 32'(cap_d_wdata), 32'h1234);
    chk("t2_mem_addr", 32'(cap_d_addr), 32'h0200);
    chk("t2_d_rdata_kept", 32'(cap_d_rdata), 32'h0000);
    @(negedge clk);

    // 3: simultaneous requests, D first
    rd_value = 16'h7777; grant_hist.delete(); base_i = n_iack; base_d = n_dack;
    fork
      do_i(16'h0044, ok);
      do_d(1'b0, 16'h0088, 16'h0000, 0, ok2);
    join
    repeat (2) @(negedge clk);
    chk("t3_n_grants", 32'(grant_hist.size()), 32'd2);
    if (grant_hist.size() >= 2) begin
      chk("t3_first_is_d", 32'(grant_hist[0]), 32'd1);
      chk("t3_second_is_i", 32'(grant_hist[1]), 32'd0);
    end
    chk("t3_one_i_ack", 32'(n_iack - base_i), 32'd1);
    chk("t3_one_d_ack", 32'(n_dack - base_d), 32'd1);

    // 4: both held continuously, streak limit lets I in after 4 D grants
    grant_hist.delete();
    fork
      do_i(16'h0100, ok);
      begin
        for (int j = 0; j < 6; j++) do_d(1'b0, ADDR_W'(16'h0400 + j), 16'h0000, j < 5, ok2);
      end
    join
    repeat (2) @(negedge clk);
    chk("t4_n_grants", 32'(grant_hist.size()), 32'd7);
    if (grant_hist.size() == 7) begin
      for (int j = 0; j < 7; j++) chk("t4_grant_order", 32'(grant_hist[j]), 32'(pat[j]));
    end
    chk("t4_streak_after_i", 32'(cap_i_streak), 32'd0);

    // 5: slow memory, D read
    ready_delay = 5; rd_value = 16'h5A5A; mreq_cycles = 0;
    do_d(1'b0, 16'h0300, 16'h0000, 0, ok);
    chk("t5_mreq_cycles", 32'(mreq_cycles), 32'd6);
    chk("t5_d_rdata", 32'(cap_d_rdata), 32'h5A5A);
    @(negedge clk);

    // 6: reset while BUSY, then a fresh fetch
    ready_delay = 50; base_i = n_iack;
    i_req = 1'b1; i_addr = 16'h0020;
    repeat (2) @(negedge clk);
    chk("t6_busy_before", 32'(o_dbg_state), 32'd1);
    reset = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_req", 32'(mem_req), 32'd0);
    chk("t6_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_state", 32'(o_dbg_state), 32'd0);
    chk("t6_i_rdata", 32'(i_rdata), 32'd0);
    chk("t6_d_rdata", 32'(d_rdata), 32'd0);
    chk("t6_no_ack", 32'(n_iack - base_i), 32'd0);
    reset = 1'b0; ready_delay = 0; rd_value = 16'h0F0F;
    @(negedge clk);
    do_i(16'h0030, ok);
    chk("t6_fresh_rdata", 32'(cap_i_rdata), 32'h0F0F);
    chk("t6_fresh_addr", 32'(cap_i_addr), 32'h0030);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
